// File: rtl/div_bus_pkg.sv
// Shared definitions for the byte-serial divider front end and back end.
// The state encoding is common to the operand loader and the result serializer.
package div_bus_pkg;

  localparam int DIV_OP_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACK   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

  function automatic int op_bytes(input int op_w);
    return op_w / 8;
  endfunction

endpackage

// File: rtl/operand_loader.sv
// Collects dividend and divisor bytes over a four-phase handshake, then
// launches the divider or flags a divide-by-zero.
module operand_loader
  import div_bus_pkg::*;
#(
  parameter int OP_W = DIV_OP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dataready,
  input  logic [7:0]      Data_in,
  output logic            readyToAccept,
  output logic [OP_W-1:0] dividend,
  output logic [OP_W-1:0] divisor,
  output logic            start,
  input  logic            div_done,
  output logic            error
);

  localparam int BYTES  = op_bytes(OP_W);
  localparam int NBYTES = 2 * BYTES;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2*OP_W-1:0] slots_q, slots_d;
  logic              rta_q, rta_d;
  logic              start_q, start_d;
  logic              error_q, error_d;

  // Next-state, byte steering and flag logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slots_d = slots_q;
    start_d = 1'b0;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (dataready) begin
          // Dividend occupies the low half, divisor the high half.
          slots_d[8*idx_q +: 8] = Data_in;
          error_d = 1'b0;
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!dataready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_CHECK;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_CHECK: begin
        if (slots_q[2*OP_W-1:OP_W] == '0) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          start_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (div_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    rta_d = (state_d == ST_ACK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      slots_q <= '0;
      rta_q   <= 1'b0;
      start_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slots_q <= slots_d;
      rta_q   <= rta_d;
      start_q <= start_d;
      error_q <= error_d;
    end
  end

  assign readyToAccept = rta_q;
  assign dividend      = slots_q[OP_W-1:0];
  assign divisor       = slots_q[2*OP_W-1:OP_W];
  assign start         = start_q;
  assign error         = error_q;

endmodule

// File: tb/tb_operand_loader.sv
// Randomized bench for operand_loader against a transaction-level model of
// the byte handshake, plus directed scenarios with hand-computed results.
module tb_operand_loader;

  localparam int OP_W  = 16;
  localparam int BYTES = OP_W / 8;
  localparam int NB    = 2 * BYTES;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            dataready = 1'b0;
  logic [7:0]      Data_in = 8'h00;
  logic            div_done = 1'b0;
  logic            readyToAccept, start, error;
  logic [OP_W-1:0] dividend, divisor;

  always #5 clk = ~clk;

  operand_loader #(.OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .dataready(dataready), .Data_in(Data_in),
    .readyToAccept(readyToAccept), .dividend(dividend), .divisor(divisor),
    .start(start), .div_done(div_done), .error(error)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  bit chk_en = 1'b0;
  bit auto_div = 1'b1;
  int busy_cnt = 0;

  // Model: received bytes plus where we are in the transaction.
  logic [7:0] m_bytes [NB];
  int m_cnt = 0;
  bit m_waiting_release = 1'b0;
  bit m_validate = 1'b0;
  bit m_divider_running = 1'b0;
  bit m_err = 1'b0;
  bit m_start = 1'b0;

  function automatic logic [OP_W-1:0] m_operand(input int which);
    logic [OP_W-1:0] r;
    r = '0;
    for (int b = 0; b < BYTES; b++) r[8*b +: 8] = m_bytes[which*BYTES + b];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NB; i++) m_bytes[i] = 8'h00;
      m_cnt = 0; m_waiting_release = 1'b0; m_validate = 1'b0;
      m_divider_running = 1'b0; m_err = 1'b0; m_start = 1'b0;
    end else begin
      m_start = 1'b0;
      if (m_validate) begin
        m_validate = 1'b0;
        if (m_operand(1) == '0) m_err = 1'b1;
        else begin m_start = 1'b1; m_divider_running = 1'b1; end
      end else if (m_divider_running) begin
        if (div_done) m_divider_running = 1'b0;
      end else if (m_waiting_release) begin
        if (!dataready) begin
          m_waiting_release = 1'b0;
          if (m_cnt == NB - 1) begin m_cnt = 0; m_validate = 1'b1; end
          else m_cnt++;
        end
      end else if (dataready) begin
        m_bytes[m_cnt] = Data_in;
        m_waiting_release = 1'b1;
        m_err = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (start === 1'b1) n_start++;
    if (chk_en) begin
      check("rta", 32'(readyToAccept), 32'(m_waiting_release));
      check("start", 32'(start), 32'(m_start));
      check("error", 32'(error), 32'(m_err));
      check("dividend", 32'(dividend), 32'(m_operand(0)));
      check("divisor", 32'(divisor), 32'(m_operand(1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_div) begin
      div_done = 1'b0;
      if (start === 1'b1) busy_cnt = $urandom_range(1, 4);
      else if (busy_cnt > 0) begin
        busy_cnt--;
        div_done = (busy_cnt == 0);
      end else div_done = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; dataready = 1'b0; div_done = 1'b0; busy_cnt = 0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    repeat ($urandom_range(0, 2)) tick();
    dataready = 1'b1; Data_in = b;
    t = 0;
    while (readyToAccept !== 1'b1 && t < 60) begin tick(); t++; end
    if (t >= 60) timeout("ack_rise");
    repeat ($urandom_range(0, 2)) tick();
    dataready = 1'b0; Data_in = 8'($urandom);
    t = 0;
    while (readyToAccept !== 1'b0 && t < 60) begin tick(); t++; end
    if (t >= 60) timeout("ack_fall");
  endtask

  task automatic send_txn(input logic [OP_W-1:0] a, input logic [OP_W-1:0] d);
    for (int i = 0; i < BYTES; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < BYTES; i++) send_byte(d[8*i +: 8]);
  endtask

  initial begin
    int s0, cnt;
    logic [OP_W-1:0] ra, rd;

    do_reset();
    check("reset_rta", 32'(readyToAccept), 32'h0);
    check("reset_start", 32'(start), 32'h0);
    check("reset_error", 32'(error), 32'h0);
    check("reset_dividend", 32'(dividend), 32'h0);
    check("reset_divisor", 32'(divisor), 32'h0);

    // Normal transaction.
    s0 = n_start;
    send_txn(16'h002D, 16'h0007);
    repeat (12) tick();
    check("t1_dividend", 32'(dividend), 32'h002D);
    check("t1_divisor", 32'(divisor), 32'h0007);
    check("t1_model_dividend", 32'(m_operand(0)), 32'h002D);
    check("t1_start_count", 32'(n_start - s0), 32'd1);
    check("t1_error", 32'(error), 32'h0);

    // Divide by zero, then the first byte of the next transaction clears error.
    s0 = n_start;
    send_txn(16'h0010, 16'h0000);
    repeat (3) tick();
    check("dz_error", 32'(error), 32'h1);
    check("dz_start_count", 32'(n_start - s0), 32'd0);
    dataready = 1'b1; Data_in = 8'h05;
    tick();
    check("dz_latch_rta", 32'(readyToAccept), 32'h1);
    check("dz_error_clear", 32'(error), 32'h0);
    check("dz_byte0", 32'(dividend), 32'h0005);
    dataready = 1'b0;
    tick();
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
    repeat (12) tick();
    check("dz_next_divisor", 32'(divisor), 32'h0003);

    // Held dataready yields exactly one byte.
    do_reset();
    dataready = 1'b1; Data_in = 8'h2D;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (readyToAccept === 1'b1) cnt++;
      tick();
    end
    dataready = 1'b0;
    tick();
    check("hold_rta_cycles", 32'(cnt), 32'd4);
    send_byte(8'h11);
    check("hold_idx_plus1", 32'(dividend), 32'h112D);
    send_byte(8'h00); send_byte(8'h00);
    repeat (3) tick();
    check("hold_dz_error", 32'(error), 32'h1);

    // Reset mid-transaction discards partial bytes.
    send_byte(8'hAA); send_byte(8'hBB);
    do_reset();
    send_txn(16'h002D, 16'h0007);
    repeat (12) tick();
    check("rst_mid_dividend", 32'(dividend), 32'h002D);
    check("rst_mid_divisor", 32'(divisor), 32'h0007);

    // dataready during BUSY, and div_done coinciding with dataready.
    auto_div = 1'b0; div_done = 1'b0;
    send_txn(16'h0102, 16'h0304);
    tick();
    check("busy_start", 32'(start), 32'h1);
    dataready = 1'b1; Data_in = 8'hA5;
    repeat (3) begin
      tick();
      check("busy_rta_low", 32'(readyToAccept), 32'h0);
    end
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    check("done_no_latch_rta", 32'(readyToAccept), 32'h0);
    check("done_no_latch_dividend", 32'(dividend), 32'h0102);
    tick();
    check("after_done_rta", 32'(readyToAccept), 32'h1);
    check("after_done_latch", 32'(dividend), 32'h01A5);
    dataready = 1'b0;
    tick();
    auto_div = 1'b1;
    do_reset();

    // Randomized transactions with occasional zero divisors and resets.
    for (int n = 0; n < 40; n++) begin
      ra = OP_W'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? '0 : OP_W'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        for (int i = 0; i < $urandom_range(1, NB - 1); i++) send_byte(8'($urandom));
        do_reset();
      end else begin
        send_txn(ra, rd);
        repeat ($urandom_range(0, 6)) tick();
      end
    end
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
